// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide unit writing the HI/LO pair; MULDIV_EARLY_EXIT_EN enables multiply early exit.
// Latency: done in cycle start+WIDTH+1 (start+1 on divide-by-zero); early exit shortens multiplies to msb(|b|)+2.
// Backpressure: busy high in CALC/DONE; start, hi_we and lo_we are ignored while busy, so the issuer must hold them.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcd;
    logic [WIDTH-1:0]   mlr;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand preparation: signed ops work on magnitudes, unsigned on raw values.
    logic             a_neg, b_neg, div_by_zero, accept;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg       = ~op[0] & a[WIDTH-1];
    assign b_neg       = ~op[0] & b[WIDTH-1];
    assign a_mag       = a_neg ? (~a + 1'b1) : a;
    assign b_mag       = b_neg ? (~b + 1'b1) : b;
    assign div_by_zero = op[1] & (b == '0);
    assign accept      = (state == IDLE) & start & ~cancel;

    // One shift-add multiply step.
    logic [2*WIDTH-1:0] acc_step, mcd_step;
    logic [WIDTH-1:0]   mlr_step;

    assign acc_step = mlr[0] ? (acc + mcd) : acc;
    assign mcd_step = mcd << 1;
    assign mlr_step = mlr >> 1;

    // One restoring divide step; the partial remainder is always below the divisor,
    // so the subtraction is exact in WIDTH bits whenever the trial fits.
    logic             fits;
    logic [WIDTH-1:0] rem_sh, rem_step, quo_step;

    assign fits     = {rem, quo[WIDTH-1]} >= {1'b0, dvs};
    assign rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign rem_step = rem_sh - (fits ? dvs : '0);
    assign quo_step = {quo[WIDTH-2:0], fits};

    logic last_step;
`ifdef MULDIV_EARLY_EXIT_EN
    // Once no multiplier bits remain the accumulator already holds the full product.
    assign last_step = (cnt == CNT_W'(1)) | (~is_div & (mlr_step == '0));
`else
    assign last_step = (cnt == CNT_W'(1));
`endif

    // Final sign correction.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    assign prod    = neg_res ? (~acc + 1'b1) : acc;
    assign quo_fix = neg_res ? (~quo + 1'b1) : quo;
    assign rem_fix = neg_rem ? (~rem + 1'b1) : rem;
    assign res_hi  = is_div ? rem_fix : prod[2*WIDTH-1:WIDTH];
    assign res_lo  = is_div ? quo_fix : prod[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_by_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
                done      = ~cancel;
                div_zero  = ~cancel & dz;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The result is shown on hi/lo during DONE and committed as DONE retires.
    assign hi = done ? res_hi : hi_q;
    assign lo = done ? res_lo : lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            acc     <= '0;
            mcd     <= '0;
            mlr     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                cnt     <= CNT_W'(WIDTH);
                is_div  <= op[1];
                dz      <= div_by_zero;
                acc     <= '0;
                mcd     <= {{WIDTH{1'b0}}, a_mag};
                mlr     <= b_mag;
                dvs     <= b_mag;
                if (div_by_zero) begin
                    neg_res <= 1'b0;
                    neg_rem <= 1'b0;
                    quo     <= '1;
                    rem     <= a;
                end else begin
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    quo     <= a_mag;
                    rem     <= '0;
                end
            end else if (state == CALC) begin
                cnt <= cnt - 1'b1;
                if (is_div) begin
                    rem <= rem_step;
                    quo <= quo_step;
                end else begin
                    acc <= acc_step;
                    mcd <= mcd_step;
                    mlr <= mlr_step;
                end
            end

            if (state == IDLE) begin
                if (hi_we) begin
                    hi_q <= wdata;
                end
                if (lo_we) begin
                    lo_q <= wdata;
                end
            end else if (done) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written corner sequences and random ops vs. an arithmetic model.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycles from the accepting edge to the done pulse (1 = first cycle after the edge).
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bv);
        if (o[1] && bv == 32'd0) return 1;
        if (o[1]) return 33;
`ifdef MULDIV_EARLY_EXIT_EN
        begin
            logic [31:0] m;
            int          l;
            m = (!o[0] && bv[31]) ? (32'd0 - bv) : bv;
            l = 2;
            for (int i = 0; i < 32; i++) if (m[i]) l = i + 2;
            return l;
        end
`else
        return 33;
`endif
    endfunction

    // Reference results from plain 64-bit arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa  = longint'($signed(av));
        sb  = longint'($signed(bv));
        ua  = {32'd0, av};
        ub  = {32'd0, bv};
        rdz = 1'b0;
        if (o[1] && bv == 32'd0) begin
            rhi = av;
            rlo = 32'hFFFF_FFFF;
            rdz = 1'b1;
        end else if (o == DIV) begin
            sq  = sa / sb;
            sr  = sa % sb;
            rlo = sq[31:0];
            rhi = sr[31:0];
        end else if (o == DIVU) begin
            rlo = 32'(ua / ub);
            rhi = 32'(ua % ub);
        end else if (o == MULT) begin
            up  = longint'(sa * sb);
            rhi = up[63:32];
            rlo = up[31:0];
        end else begin
            up  = ua * ub;
            rhi = up[63:32];
            rlo = up[31:0];
        end
    endtask

    // Drive a start at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
    endtask

    task automatic wait_done(input int k0, output int lat, output bit bok);
        int k;
        k   = k0;
        bok = 1'b1;
        lat = -1;
        while (k < 100) begin
            if (!busy) bok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        int          lat;
        bit          bok;
        logic [31:0] hsave;
        launch(o, av, bv);
        wait_done(1, lat, bok);
        check({nm, " latency"}, lat, exp_lat(o, bv));
        check({nm, " busy"}, bok, 1);
        check({nm, " hi"}, hi, ehi);
        check({nm, " lo"}, lo, elo);
        check({nm, " div_zero"}, div_zero, edz);
        hsave = hi;
        @(negedge clk);
        check({nm, " done pulse"}, done, 0);
        check({nm, " idle"}, busy, 0);
        check({nm, " hi kept"}, hi, hsave);
    endtask

    initial begin
        logic [31:0] ehi, elo, old_hi, av, bv;
        logic        edz;
        logic [1:0]  o;
        int          lat, ndone;
        bit          bok;

        vecs[0] = '{MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{MULTU, 32'd5,         32'd3,         32'd0,         32'd15,        1'b0};
        vecs[5] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[6] = '{DIVU,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
        vecs[8] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz);
        end

        // Start and MTHI during busy are both ignored.
        launch(MULTU, 32'd7, 32'hFFFF_FFFD);
        repeat (3) @(negedge clk);
        op = DIV; a = 32'h99; b = 32'd0; start = 1'b1; hi_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_done(5, lat, bok);
        check("busy-ignore latency", lat, 33);
        check("busy-ignore busy", bok, 1);
        check("busy-ignore hi", hi, 32'h6);
        check("busy-ignore lo", lo, 32'hFFFF_FFEB);
        check("busy-ignore hi not 55", hi == 32'h55, 0);
        check("busy-ignore dz", div_zero, 0);
        repeat (3) @(negedge clk);
        check("busy-ignore no restart", busy, 0);

        // Cancel mid-calculation.
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", lo, 32'hA5A5_A5A5);
        old_hi = hi;
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        check("cancel busy before", busy, 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy drop", busy, 0);
        check("cancel lo", lo, 32'hA5A5_A5A5);
        check("cancel hi", hi, old_hi);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("cancel no done", ndone, 0);

        // Cancel while in DONE suppresses the write.
        launch(DIVU, 32'd1000, 32'd10);
        wait_done(1, lat, bok);
        check("cancel-done latency", lat, 33);
        cancel = 1'b1;
        #1;
        check("cancel-done done", done, 0);
        check("cancel-done lo", lo, 32'hA5A5_A5A5);
        @(negedge clk);
        cancel = 1'b0;
        check("cancel-done idle", busy, 0);
        check("cancel-done lo kept", lo, 32'hA5A5_A5A5);
        check("cancel-done hi kept", hi, old_hi);

        // Cancel in IDLE drops a coincident start.
        op = MULTU; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel-idle drop", busy, 0);

        // MTHI coinciding with an accepted start.
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        launch(MULTU, 32'd2, 32'd3);
        check("mthi+start hi", hi, 32'hDEAD_BEEF);
        check("mthi+start busy", busy, 1);
        wait_done(1, lat, bok);
        check("mthi+start latency", lat, exp_lat(MULTU, 32'd3));
        check("mthi+start result hi", hi, 0);
        check("mthi+start result lo", lo, 6);
        @(negedge clk);

        // Reset mid-operation abandons it and clears HI/LO.
        launch(MULTU, 32'd3, 32'hFFFF_0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", busy, 0);
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            o  = 2'($urandom);
            av = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       bv = 32'd0;
                1:       bv = 32'($urandom_range(1, 15));
                2:       bv = 32'd0 - 32'($urandom_range(1, 15));
                3:       bv = 32'($urandom) >> $urandom_range(0, 31);
                default: bv = 32'($urandom);
            endcase
            model(o, av, bv, ehi, elo, edz);
            run_op($sformatf("rnd%0d", i), o, av, bv, ehi, elo, edz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
